// File: rtl/vlc_bit_packer.sv
// rtl/vlc_bit_packer.sv - MSB-first serial-to-word packer with zero-pad flush and output FIFO
// Optional build macro: VLC_PACKER_STATS_EN adds the word_count output.
module vlc_bit_packer #(
  parameter int WORD_W  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              flush,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
`ifdef VLC_PACKER_STATS_EN
  output logic              overflow,
  output logic [15:0]       word_count
`else
  output logic              overflow
`endif
);

  localparam int CW    = $clog2(WORD_W + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {FILL, FLUSH_WAIT} state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   sr, sr_d, sr_nxt, sr_shift, padded;
  logic [WORD_W-1:0]   hold, hold_d, push_data;
  logic [CW-1:0]       cnt, cnt_d, cnt_eff;
  logic [FIFO_AW:0]    wptr, rptr;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic                bit_in, push, pop, full, can_push, ovf_set;

  assign pop        = dout_valid && dout_ready;
  assign full       = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign can_push   = !full || pop;
  assign dout_valid = (wptr != rptr);
  assign dout       = mem[rptr[FIFO_AW-1:0]];
  assign busy       = (cnt != '0) || (state == FLUSH_WAIT);

  // Bits arriving while a padded word is stuck waiting are not packed.
  assign bit_in   = din_valid && (state == FILL);
  assign sr_shift = {sr[WORD_W-2:0], din};
  assign sr_nxt   = bit_in ? sr_shift : sr;
  assign cnt_eff  = bit_in ? cnt + CW'(1) : cnt;
  assign padded   = sr_nxt << (CW'(WORD_W) - cnt_eff);

  // Next-state, packing and push decision; a completed word takes priority over flush.
  always_comb begin
    state_nxt = state;
    sr_d      = sr_nxt;
    cnt_d     = cnt_eff;
    hold_d    = hold;
    push      = 1'b0;
    push_data = sr_shift;
    ovf_set   = 1'b0;
    case (state)
      FILL: begin
        if (bit_in && (cnt == CW'(WORD_W - 1))) begin
          cnt_d = '0;
          if (can_push) push = 1'b1;
          else          ovf_set = 1'b1;
        end else if (flush && (cnt_eff != '0)) begin
          cnt_d = '0;
          if (can_push) begin
            push      = 1'b1;
            push_data = padded;
          end else begin
            state_nxt = FLUSH_WAIT;
            hold_d    = padded;
          end
        end
      end
      FLUSH_WAIT: begin
        if (din_valid) ovf_set = 1'b1;
        if (can_push) begin
          push      = 1'b1;
          push_data = hold;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Packer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      sr       <= '0;
      cnt      <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_d;
      cnt   <= cnt_d;
      hold  <= hold_d;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Output FIFO storage and pointers; the extra pointer MSB separates full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[FIFO_AW-1:0]] <= push_data;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

`ifdef VLC_PACKER_STATS_EN
  // Count words actually accepted into the FIFO; dropped words are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      word_count <= '0;
    else if (push) word_count <= word_count + 16'd1;
  end
`endif

endmodule
